// File: rtl/gps_sweep_pkg.sv
// gps_sweep_pkg: shared types for the GPS sweep controller.
//   state_e       - sequencer states
//   sweep_entry_t - one captured result (276 bits) as stored in the FIFO
package gps_sweep_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT,
        ST_STORE
    } state_e;

    typedef struct packed {
        logic [5:0]   sv;
        logic [12:0]  ca;
        logic [127:0] p;
        logic [127:0] l;
        logic         timeout;
    } sweep_entry_t;

endpackage

// File: rtl/gps_sweep_fifo.sv
// gps_sweep_fifo: first-word fall-through FIFO of sweep_entry_t.
// Ports:
//   clk, rst_n   - clock, asynchronous active-low reset
//   push, din    - write request and data (accepted when not full, or when
//                  full with a pop in the same cycle)
//   pop          - read request (ignored when empty)
//   head         - current head entry (all zeros when empty)
//   full, empty  - occupancy flags
module gps_sweep_fifo
    import gps_sweep_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push,
    input  sweep_entry_t din,
    input  logic         pop,
    output sweep_entry_t head,
    output logic         full,
    output logic         empty
);

    localparam int unsigned AW = $clog2(DEPTH);

    // Extra MSB on each pointer is the wrap bit that separates full from empty.
    logic [AW:0]  wr_ptr;
    logic [AW:0]  rd_ptr;
    sweep_entry_t mem [DEPTH];
    logic         do_pop;
    logic         do_push;

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= din;
    end

    // Head masked while empty so the read port reads zero out of reset.
    assign head = empty ? '0 : mem[rd_ptr[AW-1:0]];

endmodule

// File: rtl/gps_sweep_ctrl.sv
// gps_sweep_ctrl: walks SV_FIRST..SV_LAST, starts one core round per SV,
// captures the core outputs on the rising edge of l_code_valid (or a
// timeout record) and queues each result in a FWFT FIFO.
// Ports:
//   sys_clk_50, rst_n          - clock, asynchronous active-low reset
//   start, abort               - sweep request / stop (abort has priority)
//   busy, done                 - not-idle flag, end-of-sweep pulse
//   sv_num, startRound         - to the code generator core
//   ca_code, p_code, l_code,
//   l_code_valid               - from the code generator core
//   rd_valid, rd_ready         - FIFO read handshake
//   rd_sv, rd_ca, rd_p, rd_l,
//   rd_timeout                 - FIFO head entry fields
//   timeout_cnt                - saturating timeout count since reset
module gps_sweep_ctrl
    import gps_sweep_pkg::*;
#(
    parameter int unsigned SV_FIRST       = 1,
    parameter int unsigned SV_LAST        = 32,
    parameter int unsigned DEPTH          = 4,
    parameter int unsigned TIMEOUT_CYCLES = 4096
) (
    input  logic         sys_clk_50,
    input  logic         rst_n,
    input  logic         start,
    input  logic         abort,
    output logic         busy,
    output logic         done,
    output logic [5:0]   sv_num,
    output logic         startRound,
    input  logic [12:0]  ca_code,
    input  logic [127:0] p_code,
    input  logic [127:0] l_code,
    input  logic         l_code_valid,
    output logic         rd_valid,
    input  logic         rd_ready,
    output logic [5:0]   rd_sv,
    output logic [12:0]  rd_ca,
    output logic [127:0] rd_p,
    output logic [127:0] rd_l,
    output logic         rd_timeout,
    output logic [7:0]   timeout_cnt
);

    localparam int unsigned TW    = $clog2(TIMEOUT_CYCLES);
    localparam logic [TW-1:0] TLAST = TW'(TIMEOUT_CYCLES - 1);

    state_e       state;
    logic [TW-1:0] tcnt;
    logic         vld_q;
    sweep_entry_t cap;
    sweep_entry_t head;
    logic         fifo_full;
    logic         fifo_empty;
    logic         pop;
    logic         push;
    logic         rise;

    assign rise = l_code_valid & ~vld_q;
    assign pop  = rd_ready & ~fifo_empty;
    // A full FIFO still accepts the push when the head leaves in the same cycle.
    assign push = (state == ST_STORE) & ~abort & (~fifo_full | pop);
    assign busy = (state != ST_IDLE);

    always_ff @(posedge sys_clk_50 or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ST_IDLE;
            sv_num      <= '0;
            startRound  <= 1'b0;
            done        <= 1'b0;
            tcnt        <= '0;
            vld_q       <= 1'b0;
            cap         <= '0;
            timeout_cnt <= '0;
        end else begin
            startRound <= 1'b0;
            done       <= 1'b0;
            vld_q      <= l_code_valid;
            if (abort) begin
                state <= ST_IDLE;
            end else begin
                case (state)
                    ST_IDLE: begin
                        if (start) begin
                            sv_num     <= 6'(SV_FIRST);
                            startRound <= 1'b1;
                            state      <= ST_ISSUE;
                        end
                    end
                    ST_ISSUE: begin
                        tcnt  <= '0;
                        // Pretend valid was already high so a level left over
                        // from the previous round cannot look like an edge.
                        vld_q <= 1'b1;
                        state <= ST_WAIT;
                    end
                    ST_WAIT: begin
                        if (rise) begin
                            cap   <= '{sv: sv_num, ca: ca_code, p: p_code, l: l_code, timeout: 1'b0};
                            state <= ST_STORE;
                        end else if (tcnt == TLAST) begin
                            cap   <= '{sv: sv_num, ca: '0, p: '0, l: '0, timeout: 1'b1};
                            if (timeout_cnt != 8'hFF) timeout_cnt <= timeout_cnt + 8'd1;
                            state <= ST_STORE;
                        end else begin
                            tcnt <= tcnt + 1'b1;
                        end
                    end
                    ST_STORE: begin
                        if (push) begin
                            if (sv_num == 6'(SV_LAST)) begin
                                done  <= 1'b1;
                                state <= ST_IDLE;
                            end else begin
                                sv_num     <= sv_num + 6'd1;
                                startRound <= 1'b1;
                                state      <= ST_ISSUE;
                            end
                        end
                    end
                    default: state <= ST_IDLE;
                endcase
            end
        end
    end

    gps_sweep_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk   (sys_clk_50),
        .rst_n (rst_n),
        .push  (push),
        .din   (cap),
        .pop   (pop),
        .head  (head),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    assign rd_valid   = ~fifo_empty;
    assign rd_sv      = head.sv;
    assign rd_ca      = head.ca;
    assign rd_p       = head.p;
    assign rd_l       = head.l;
    assign rd_timeout = head.timeout;

endmodule

// File: tb/tb_gps_sweep_ctrl.sv
// tb_gps_sweep_ctrl: table-driven sweeps plus hand sequences for
// backpressure, abort and asynchronous reset of gps_sweep_ctrl.
module tb_gps_sweep_ctrl;

    localparam int TMO = 16;
    localparam int NSV = 8;

    logic         sys_clk_50;
    logic         rst_n;
    logic         start;
    logic         abort;
    logic         busy;
    logic         done;
    logic [5:0]   sv_num;
    logic         startRound;
    logic [12:0]  ca_code;
    logic [127:0] p_code;
    logic [127:0] l_code;
    logic         l_code_valid;
    logic         rd_valid;
    logic         rd_ready;
    logic [5:0]   rd_sv;
    logic [12:0]  rd_ca;
    logic [127:0] rd_p;
    logic [127:0] rd_l;
    logic         rd_timeout;
    logic [7:0]   timeout_cnt;

    gps_sweep_ctrl #(
        .SV_FIRST       (1),
        .SV_LAST        (NSV),
        .DEPTH          (4),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .sys_clk_50   (sys_clk_50),
        .rst_n        (rst_n),
        .start        (start),
        .abort        (abort),
        .busy         (busy),
        .done         (done),
        .sv_num       (sv_num),
        .startRound   (startRound),
        .ca_code      (ca_code),
        .p_code       (p_code),
        .l_code       (l_code),
        .l_code_valid (l_code_valid),
        .rd_valid     (rd_valid),
        .rd_ready     (rd_ready),
        .rd_sv        (rd_sv),
        .rd_ca        (rd_ca),
        .rd_p         (rd_p),
        .rd_l         (rd_l),
        .rd_timeout   (rd_timeout),
        .timeout_cnt  (timeout_cnt)
    );

    initial sys_clk_50 = 1'b0;
    always #5 sys_clk_50 = ~sys_clk_50;

    int checks = 0;
    int errors = 0;

    // Core model controls
    int core_lat = 10;
    int skip_sv  = 0;
    bit stale    = 1'b0;

    // Scoreboard
    typedef struct {
        logic [5:0] sv;
        logic       tmo;
    } exp_t;
    exp_t sbq[$];
    exp_t e;
    int exp_next_sv = 1;
    int n_rounds = 0;
    int n_pops   = 0;
    int n_done   = 0;

    typedef struct {
        int lat;
        int skip;
        bit stl;
        int exp_to;
    } vec_t;

    function automatic logic [12:0] f_ca(input logic [5:0] sv);
        return 13'h1234 ^ {7'd0, sv} ^ {sv, 7'd0};
    endfunction

    function automatic logic [127:0] f_p(input logic [5:0] sv);
        return {4{26'h2A5A5A5, sv}};
    endfunction

    function automatic logic [127:0] f_l(input logic [5:0] sv);
        return ~f_p(sv) ^ {122'd0, sv};
    endfunction

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Core model: valid rises core_lat cycles after startRound and stays high
    // until the next round; in stale mode the old level lingers into WAIT.
    initial begin
        int         cnt;
        logic [5:0] cur;
        cnt = 0;
        cur = '0;
        l_code_valid = 1'b0;
        ca_code = '0;
        p_code  = '0;
        l_code  = '0;
        forever begin
            @(posedge sys_clk_50);
            #1;
            if (startRound) begin
                cnt = core_lat;
                cur = sv_num;
                if (!stale) l_code_valid = 1'b0;
            end else if (cnt > 0) begin
                cnt--;
                if (cnt == core_lat - 4) l_code_valid = 1'b0;
                if (cnt == 0 && int'(cur) != skip_sv) begin
                    ca_code = f_ca(cur);
                    p_code  = f_p(cur);
                    l_code  = f_l(cur);
                    l_code_valid = 1'b1;
                end
            end
        end
    end

    // Monitor: issue order, scoreboard push on issue, compare on pop.
    always @(negedge sys_clk_50) begin
        if (rst_n) begin
            if (startRound) begin
                chk("round_sv", sv_num, exp_next_sv);
                sbq.push_back('{sv: 6'(exp_next_sv),
                                tmo: (exp_next_sv == skip_sv) || (core_lat > TMO)});
                exp_next_sv++;
                n_rounds++;
            end
            if (rd_valid && rd_ready) begin
                if (sbq.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL pop_unexpected actual=sv%0d expected=none", rd_sv);
                end else begin
                    e = sbq.pop_front();
                    chk("rd_sv", rd_sv, e.sv);
                    chk("rd_timeout", rd_timeout, e.tmo);
                    chk("rd_ca", rd_ca, e.tmo ? 13'd0 : f_ca(e.sv));
                    chk("rd_p", rd_p, e.tmo ? 128'd0 : f_p(e.sv));
                    chk("rd_l", rd_l, e.tmo ? 128'd0 : f_l(e.sv));
                end
                n_pops++;
            end
            if (done) n_done++;
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge sys_clk_50);
        #1;
    endtask

    task automatic pulse_start();
        exp_next_sv = 1;
        start = 1'b1;
        @(posedge sys_clk_50);
        #1;
        start = 1'b0;
    endtask

    task automatic wait_done(input string name, input int budget);
        int i;
        i = 0;
        while (!done && i < budget) begin
            @(negedge sys_clk_50);
            i++;
        end
        checks++;
        if (!done) begin
            errors++;
            $display("FAIL %s_done actual=no_done expected=done_within_%0d", name, budget);
        end
        @(negedge sys_clk_50);
        chk({name, "_busy_after_done"}, busy, 1'b0);
        chk({name, "_done_one_cycle"}, done, 1'b0);
    endtask

    task automatic wait_rounds(input string name, input int k, input int budget);
        int i;
        i = 0;
        while (n_rounds < k && i < budget) begin
            @(posedge sys_clk_50);
            i++;
        end
        #1;
        checks++;
        if (n_rounds < k) begin
            errors++;
            $display("FAIL %s_rounds actual=%0d expected=%0d", name, n_rounds, k);
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_busy"}, busy, 1'b0);
        chk({tag, "_done"}, done, 1'b0);
        chk({tag, "_sv_num"}, sv_num, 6'd0);
        chk({tag, "_startRound"}, startRound, 1'b0);
        chk({tag, "_rd_valid"}, rd_valid, 1'b0);
        chk({tag, "_rd_sv"}, rd_sv, 6'd0);
        chk({tag, "_rd_ca"}, rd_ca, 13'd0);
        chk({tag, "_rd_p"}, rd_p, 128'd0);
        chk({tag, "_rd_l"}, rd_l, 128'd0);
        chk({tag, "_rd_timeout"}, rd_timeout, 1'b0);
        chk({tag, "_timeout_cnt"}, timeout_cnt, 8'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog actual=running expected=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vecs[5];
        int   exp_tcnt;
        string nm;

        vecs[0] = '{lat: 10, skip: 0, stl: 1'b0, exp_to: 0};   // basic sweep
        vecs[1] = '{lat: 3,  skip: 2, stl: 1'b0, exp_to: 1};   // SV 2 never answers
        vecs[2] = '{lat: 6,  skip: 0, stl: 1'b1, exp_to: 0};   // stale valid into ISSUE
        vecs[3] = '{lat: 15, skip: 0, stl: 1'b0, exp_to: 0};   // edge on WAIT cycle 15
        vecs[4] = '{lat: 17, skip: 0, stl: 1'b0, exp_to: NSV}; // every SV times out

        rst_n    = 1'b0;
        start    = 1'b0;
        abort    = 1'b0;
        rd_ready = 1'b0;
        #1;
        chk_all_zero("reset");
        cyc(3);
        rst_n = 1'b1;
        cyc(2);

        exp_tcnt = 0;
        for (int v = 0; v < 5; v++) begin
            nm = $sformatf("vec%0d", v);
            core_lat = vecs[v].lat;
            skip_sv  = vecs[v].skip;
            stale    = vecs[v].stl;
            rd_ready = 1'b1;
            n_rounds = 0;
            n_pops   = 0;
            n_done   = 0;
            pulse_start();
            chk({nm, "_startRound_after_start"}, startRound, 1'b1);
            chk({nm, "_busy_after_start"}, busy, 1'b1);
            chk({nm, "_sv_first"}, sv_num, 6'd1);
            wait_done(nm, 1000);
            cyc(4);
            exp_tcnt += vecs[v].exp_to;
            chk({nm, "_rounds"}, n_rounds, NSV);
            chk({nm, "_pops"}, n_pops, NSV);
            chk({nm, "_done_count"}, n_done, 1);
            chk({nm, "_timeout_cnt"}, timeout_cnt, exp_tcnt);
            chk({nm, "_sb_empty"}, sbq.size(), 0);
        end
        stale   = 1'b0;
        skip_sv = 0;

        // Backpressure: FIFO fills with SV 1..4, SV 5 stalls in STORE.
        core_lat = 3;
        rd_ready = 1'b0;
        n_rounds = 0;
        n_pops   = 0;
        n_done   = 0;
        pulse_start();
        cyc(150);
        chk("bp_rounds_stalled", n_rounds, 5);
        chk("bp_sv_num", sv_num, 6'd5);
        chk("bp_busy", busy, 1'b1);
        chk("bp_rd_valid", rd_valid, 1'b1);
        chk("bp_head_stable", rd_sv, 6'd1);
        chk("bp_no_done", n_done, 0);
        rd_ready = 1'b1;
        wait_done("bp", 500);
        cyc(4);
        chk("bp_pops", n_pops, NSV);
        chk("bp_sb_empty", sbq.size(), 0);

        // Abort mid-WAIT on SV 2 with SV 1 held in the FIFO.
        core_lat = 10;
        rd_ready = 1'b0;
        n_rounds = 0;
        n_pops   = 0;
        n_done   = 0;
        pulse_start();
        wait_rounds("abort", 2, 200);
        cyc(3);
        abort = 1'b1;
        cyc(1);
        abort = 1'b0;
        chk("abort_busy", busy, 1'b0);
        void'(sbq.pop_back());
        cyc(20);
        chk("abort_no_done", n_done, 0);
        chk("abort_idle", busy, 1'b0);
        chk("abort_kept_valid", rd_valid, 1'b1);
        chk("abort_kept_sv", rd_sv, 6'd1);
        start = 1'b1;
        abort = 1'b1;
        cyc(1);
        start = 1'b0;
        abort = 1'b0;
        chk("start_abort_busy", busy, 1'b0);
        chk("start_abort_startRound", startRound, 1'b0);
        cyc(2);
        pulse_start();
        chk("restart_sv_first", sv_num, 6'd1);
        chk("restart_startRound", startRound, 1'b1);
        rd_ready = 1'b1;
        wait_done("restart", 1000);
        cyc(4);
        chk("restart_pops", n_pops, NSV + 1);
        chk("restart_sb_empty", sbq.size(), 0);

        // Asynchronous reset while in WAIT, with entries queued.
        rd_ready = 1'b0;
        n_rounds = 0;
        pulse_start();
        wait_rounds("rst", 2, 200);
        cyc(2);
        #3;
        rst_n = 1'b0;
        #1;
        chk_all_zero("midrst");
        sbq.delete();
        cyc(2);
        rst_n = 1'b1;
        cyc(3);
        chk("post_rst_busy", busy, 1'b0);
        chk("post_rst_rd_valid", rd_valid, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/gps_sweep_ctrl.md
# gps_sweep_ctrl

Sequencer that sits directly upstream and downstream of the GPS code generator core. It walks the satellite range, drives `sv_num` and pulses `startRound` once per SV, and captures the resulting `ca_code` / `p_code` / `l_code` when `l_code_valid` rises. Each capture lands in a small first-word-fall-through FIFO that the bus/host side drains with a valid/ready handshake. A per-SV timeout keeps a hung round from stalling the sweep.

## Interface
Parameters:
- `SV_FIRST`, default 1: first satellite number issued (1..63).
- `SV_LAST`, default 32: last satellite number issued (≥ `SV_FIRST`, ≤ 63).
- `DEPTH`, default 4: FIFO entries, power of two, ≥ 2.
- `TIMEOUT_CYCLES`, default 4096: maximum WAIT cycles per SV (≥ 2).

Ports:
- `sys_clk_50`, in, 1: clock. All logic uses one clock.
- `rst_n`, in, 1: reset, asynchronous, active-low.
- `start`, in, 1: single-cycle sweep request; ignored while `busy`.
- `abort`, in, 1: stop the sweep; takes priority over all other events.
- `busy`, out, 1: high in any state other than IDLE.
- `done`, out, 1: one-cycle pulse after the last SV entry is pushed.
- `sv_num`, out, 6: to the core; registered.
- `startRound`, out, 1: to the core; one-cycle pulse per SV.
- `ca_code`, in, 13: from the core.
- `p_code`, in, 128: from the core.
- `l_code`, in, 128: from the core.
- `l_code_valid`, in, 1: from the core.
- `rd_valid`, out, 1: FIFO head is valid.
- `rd_ready`, in, 1: consumer accepts the head; a pop occurs when `rd_valid & rd_ready`.
- `rd_sv`, out, 6: SV number of the head entry.
- `rd_ca`, out, 13: `ca_code` of the head entry.
- `rd_p`, out, 128: `p_code` of the head entry.
- `rd_l`, out, 128: `l_code` of the head entry.
- `rd_timeout`, out, 1: head entry was produced by a timeout.
- `timeout_cnt`, out, 8: saturating count of timeouts since reset.

## Operation
- States: IDLE, ISSUE, WAIT, STORE.
- IDLE: `start` moves to ISSUE with `sv_num` = `SV_FIRST`.
- ISSUE: lasts one cycle, with `startRound` = 1. Clears the timeout counter and moves to WAIT.
- WAIT:
  - A 0→1 edge of `l_code_valid` latches `{sv_num, ca_code, p_code, l_code, timeout=0}` into the capture register and moves to STORE.
  - The edge is detected against a registered copy of `l_code_valid`. That copy is forced to 1 in ISSUE, so a stale high level never triggers a capture.
  - If `TIMEOUT_CYCLES` WAIT cycles elapse with no edge, the block latches `{sv_num, 0, 0, 0, timeout=1}`, increments `timeout_cnt` (saturating at 255) and moves to STORE.
- STORE: push the capture register when the FIFO is not full, or when it is full and a pop occurs in the same cycle. Otherwise hold in STORE (backpressure).
  - After the push: if `sv_num` == `SV_LAST`, pulse `done` and go to IDLE; else `sv_num`+1 and go to ISSUE.
- `sv_num` holds its value through WAIT and STORE. It keeps the last issued value in IDLE.
- `abort`, in any state: go to IDLE on the next edge. No push, no `done`. The FIFO contents and `timeout_cnt` are kept.
- `start` together with `abort`: abort wins.
- The FIFO is first-word fall-through. Head fields are stable while `rd_valid` and not `rd_ready`.

## Timing
- Reset values: all outputs 0, state IDLE, FIFO empty, `l_code_valid` history register 0.
- `start` at edge N → `startRound` high during cycle N+1, with `busy` high from N+1.
- Rising `l_code_valid` seen at edge M → state STORE at M+1. The push happens at M+1 if there is space, and `rd_valid` rises at M+2 when the FIFO was empty.
- Unstalled per-SV overhead is 3 cycles plus the core latency: ISSUE 1 cycle, edge detect 1 cycle, STORE 1 cycle.
- A timeout occurs on the `TIMEOUT_CYCLES`-th WAIT cycle.
- Pop and push in the same cycle when full: both happen, and the count stays at `DEPTH`.
- Pop on an empty FIFO: ignored.

## Structure
- Package `gps_sweep_pkg`:
  - `state_e` enum.
  - `sweep_entry_t` struct: `sv[5:0]`, `ca[12:0]`, `p[127:0]`, `l[127:0]`, `timeout` (276 bits).
- Sub-module `gps_sweep_fifo`, parameterised on `DEPTH`, storing `sweep_entry_t`:
  - Pointers are `$clog2(DEPTH)`+1 bits wide, with full/empty decided by comparing the wrap bit.
  - Exposes `full`, `empty`, push and pop.
- The top module holds the FSM, the timeout counter, the edge detect and the capture register.

## Test plan
- **Basic sweep.** `SV_FIRST`=1, `SV_LAST`=3. The core model raises `l_code_valid` 10 cycles after each `startRound`, and `rd_ready`=1.
  - Expect exactly 3 `startRound` pulses with `sv_num` 1, 2, 3.
  - Expect 3 entries with `rd_sv` 1, 2, 3 and matching codes.
  - Expect one `done` pulse, with `busy` low the cycle after it.
- **Backpressure.** `DEPTH`=4, 8 SVs, `rd_ready`=0.
  - The FSM stalls in STORE on SV 5, with no 5th `startRound`.
  - Releasing `rd_ready` drains SV 1..8 in order with no loss or duplication.
- **Timeout.** The core never asserts valid for SV 2, with `TIMEOUT_CYCLES`=16.
  - The SV 2 entry has `rd_timeout`=1 and zero codes, and `timeout_cnt`=1.
  - SV 3 is still issued.
- **Stale valid.** `l_code_valid` stays high from the previous round into ISSUE.
  - No capture happens until it falls and rises again.
- **Abort mid-WAIT on SV 2.**
  - State is IDLE next cycle, with no `done` and the SV 1 entry kept.
  - A new `start` restarts at `SV_FIRST`.
- **Reset mid-sweep.** `rst_n` is asserted asynchronously while in WAIT.
  - All outputs go to 0 immediately, with the FIFO empty and `timeout_cnt`=0.
